// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig
//   Run-time reconfiguration sequencer for the system PLL via its DRP port.
//   On an accepted start it holds the PLL in reset, read-modify-writes every
//   entry of a register table, releases reset and waits for re-lock.
//   Clocked from the buffered board clock (DRP DCLK), never from a PLL output.
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               start request, accepted only while idle
//   tbl_addr_i            DRP address per entry, entry k at [7k+:7]
//   tbl_mask_i            keep mask per entry (1 = keep current bit), [16k+:16]
//   tbl_data_i            new data per entry, [16k+:16]
//   busy_o, done_o        sequence in progress / 1-cycle end pulse
//   err_o, err_lock_o     sticky error / error cause was lock timeout
//   pll_rst_o             PLL reset
//   daddr_o, den_o, dwe_o, di_o, do_i, drdy_i   DRP port
//   locked_i              asynchronous PLL lock, synchronised internally
module pll_drp_reconfig #(
   parameter int unsigned NUM_REGS     = 8,
   parameter int unsigned RST_HOLD     = 4,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [7*NUM_REGS-1:0]    tbl_addr_i,
   input  logic [16*NUM_REGS-1:0]   tbl_mask_i,
   input  logic [16*NUM_REGS-1:0]   tbl_data_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     err_lock_o,
   output logic                     pll_rst_o,
   output logic [6:0]               daddr_o,
   output logic                     den_o,
   output logic                     dwe_o,
   output logic [15:0]              di_o,
   input  logic [15:0]              do_i,
   input  logic                     drdy_i,
   input  logic                     locked_i
);

   localparam int unsigned      IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [15:0]      HOLD_END = 16'(RST_HOLD - 1);
   localparam logic [15:0]      DRDY_TO  = 16'(DRDY_TIMEOUT);
   localparam logic [15:0]      LOCK_TO  = 16'(LOCK_TIMEOUT);

   typedef enum logic [3:0] {
      S_IDLE, S_RST_PRE, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
      S_RST_POST, S_LOCK_WAIT, S_ERR, S_FIN
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      cnt_q, cnt_d, cnt_inc;
   logic [6:0]       daddr_q, daddr_d;
   logic [15:0]      di_q, di_d;
   logic             pll_rst_q, pll_rst_d;
   logic             err_q, err_d;
   logic             err_lock_q, err_lock_d;
   logic             lock_meta_q, lock_sync_q;
   logic             accept;

   logic [6:0]       addr_tbl_q [NUM_REGS];
   logic [15:0]      mask_tbl_q [NUM_REGS];
   logic [15:0]      data_tbl_q [NUM_REGS];

   assign accept  = (state_q == S_IDLE) && start_i;
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      daddr_d    = daddr_q;
      di_d       = di_q;
      pll_rst_d  = pll_rst_q;
      err_d      = err_q;
      err_lock_d = err_lock_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_RST_PRE;
               idx_d      = '0;
               cnt_d      = '0;
               err_d      = 1'b0;
               err_lock_d = 1'b0;
               pll_rst_d  = 1'b1;
            end
         end
         S_RST_PRE: begin
            if (cnt_q >= HOLD_END) state_d = S_RD;
            else                   cnt_d   = cnt_inc;
         end
         S_RD: begin
            state_d = S_RD_WAIT;
            cnt_d   = '0;
         end
         S_RD_WAIT: begin
            // drdy is checked before the timeout so a same-cycle response wins
            if (drdy_i) begin
               state_d = S_WR;
               di_d    = (do_i & mask_tbl_q[idx_q]) | (data_tbl_q[idx_q] & ~mask_tbl_q[idx_q]);
            end else if (cnt_q >= DRDY_TO) begin
               state_d   = S_ERR;
               err_d     = 1'b1;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WR: begin
            state_d = S_WR_WAIT;
            cnt_d   = '0;
         end
         S_WR_WAIT: begin
            if (drdy_i) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_RST_POST;
                  cnt_d   = '0;
               end else begin
                  state_d = S_RD;
                  idx_d   = idx_q + 1'b1;
               end
            end else if (cnt_q >= DRDY_TO) begin
               state_d   = S_ERR;
               err_d     = 1'b1;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RST_POST: begin
            if (cnt_q >= HOLD_END) begin
               state_d   = S_LOCK_WAIT;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_LOCK_WAIT: begin
            if (lock_sync_q) begin
               state_d = S_FIN;
            end else if (cnt_q >= LOCK_TO) begin
               state_d    = S_ERR;
               err_d      = 1'b1;
               err_lock_d = 1'b1;
               pll_rst_d  = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_ERR: begin
            state_d   = S_FIN;
            pll_rst_d = 1'b0;
         end
         S_FIN: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase

      // Address is loaded on entry to RD and simply held through WR and idle
      if (state_d == S_RD) daddr_d = addr_tbl_q[idx_d];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         daddr_q     <= '0;
         di_q        <= '0;
         pll_rst_q   <= 1'b0;
         err_q       <= 1'b0;
         err_lock_q  <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            addr_tbl_q[k] <= '0;
            mask_tbl_q[k] <= '0;
            data_tbl_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         daddr_q     <= daddr_d;
         di_q        <= di_d;
         pll_rst_q   <= pll_rst_d;
         err_q       <= err_d;
         err_lock_q  <= err_lock_d;
         lock_meta_q <= locked_i;
         lock_sync_q <= lock_meta_q;
         if (accept) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
               addr_tbl_q[k] <= tbl_addr_i[7*k +: 7];
               mask_tbl_q[k] <= tbl_mask_i[16*k +: 16];
               data_tbl_q[k] <= tbl_data_i[16*k +: 16];
            end
         end
      end
   end

   assign busy_o     = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done_o     = (state_q == S_FIN);
   assign den_o      = (state_q == S_RD) || (state_q == S_WR);
   assign dwe_o      = (state_q == S_WR);
   assign daddr_o    = daddr_q;
   assign di_o       = di_q;
   assign pll_rst_o  = pll_rst_q;
   assign err_o      = err_q;
   assign err_lock_o = err_lock_q;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// tb_pll_drp_reconfig
//   Directed bench for pll_drp_reconfig with a 2-entry table, a behavioural
//   DRP slave (programmable response delay) and a PLL lock model.
module tb_pll_drp_reconfig;

   localparam int unsigned NREG = 2;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                start_i;
   logic [7*NREG-1:0]   tbl_addr_i;
   logic [16*NREG-1:0]  tbl_mask_i;
   logic [16*NREG-1:0]  tbl_data_i;
   logic                busy_o, done_o, err_o, err_lock_o, pll_rst_o;
   logic [6:0]          daddr_o;
   logic                den_o, dwe_o;
   logic [15:0]         di_o;
   logic [15:0]         do_i;
   logic                drdy_i;
   logic                locked_i;

   pll_drp_reconfig #(
      .NUM_REGS     (NREG),
      .RST_HOLD     (4),
      .DRDY_TIMEOUT (64),
      .LOCK_TIMEOUT (65535)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .tbl_addr_i (tbl_addr_i),
      .tbl_mask_i (tbl_mask_i),
      .tbl_data_i (tbl_data_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_lock_o (err_lock_o),
      .pll_rst_o  (pll_rst_o),
      .daddr_o    (daddr_o),
      .den_o      (den_o),
      .dwe_o      (dwe_o),
      .di_o       (di_o),
      .do_i       (do_i),
      .drdy_i     (drdy_i),
      .locked_i   (locked_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration (written by the test tasks only)
   int          drp_delay  = 1;
   bit          drp_never  = 1'b0;
   bit          drp_rand   = 1'b0;
   bit          spur_en    = 1'b0;
   int          lock_delay = 10;
   logic [15:0] rd_val [128];

   // slave observations (written by the model only)
   logic [6:0]  acc_addr [$];
   bit          acc_we   [$];
   logic [15:0] acc_data [$];
   int          acc_cyc  [$];
   int viol_b2b = 0, viol_out = 0, viol_rst = 0, viol_we = 0;
   int done_cnt = 0, rst_fall_cyc = 0, lock_rise_cyc = 0;

   // DRP slave + PLL lock model, driven on the falling edge
   initial begin : drp_model
      int          pend;
      logic [15:0] pend_data;
      bit          den_prev;
      bit          rst_was_high;
      int          lock_cnt;
      pend = 0; pend_data = '0; den_prev = 1'b0; rst_was_high = 1'b0; lock_cnt = 0;
      drdy_i = 1'b0; do_i = '0; locked_i = 1'b0;
      forever begin
         @(negedge clk_i);
         drdy_i = 1'b0;
         if (rst_i || !busy_o) begin
            pend = 0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               drdy_i = 1'b1;
               do_i   = pend_data;
            end
         end
         if (spur_en && !rst_i && !busy_o && !drdy_i) begin
            drdy_i = 1'($urandom_range(0, 1));
            do_i   = 16'($urandom);
         end
         if (den_o) begin
            if (den_prev)  viol_b2b++;
            if (pend != 0) viol_out++;
            if (!pll_rst_o) viol_rst++;
            acc_addr.push_back(daddr_o);
            acc_we.push_back(dwe_o);
            acc_data.push_back(di_o);
            acc_cyc.push_back(cyc);
            pend_data = rd_val[daddr_o];
            if (drp_never)     pend = -1;
            else if (drp_rand) pend = int'($urandom_range(1, 63));
            else               pend = drp_delay;
         end else if (dwe_o) begin
            viol_we++;
         end
         den_prev = den_o;
         if (pll_rst_o) begin
            locked_i     = 1'b0;
            lock_cnt     = 0;
            rst_was_high = 1'b1;
         end else begin
            if (rst_was_high) begin
               rst_fall_cyc = cyc;
               rst_was_high = 1'b0;
            end
            if (lock_delay >= 0 && !locked_i) begin
               if (lock_cnt == lock_delay) begin
                  locked_i      = 1'b1;
                  lock_rise_cyc = cyc;
               end
               lock_cnt++;
            end
         end
         if (done_o) done_cnt++;
      end
   end

   task automatic pulse_start();
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit seen, output int at_cyc);
      seen   = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk_i);
         #1;
         if (done_o) begin
            seen   = 1'b1;
            at_cyc = cyc;
         end
      end
   endtask

   task automatic set_default_table();
      tbl_addr_i = {7'h14, 7'h08};
      tbl_mask_i = {16'hFF00, 16'hFF00};
      tbl_data_i = {16'h1234, 16'h1234};
      rd_val[7'h08] = 16'hA5A5;
      rd_val[7'h14] = 16'hA5A5;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      n_checks++;
      if ({busy_o, done_o, err_o, err_lock_o, pll_rst_o, den_o, dwe_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000000",
                  {busy_o, done_o, err_o, err_lock_o, pll_rst_o, den_o, dwe_o});
      end
      n_checks++;
      if ({daddr_o, di_o} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_bus: daddr=%h di=%h want 0", daddr_o, di_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_rmw();
      bit seen; int dc; int b; int vr;
      set_default_table();
      drp_never = 1'b0; drp_rand = 1'b0; drp_delay = 1; lock_delay = 10;
      b  = acc_addr.size();
      vr = viol_rst;
      pulse_start();
      // post-accept input changes must not reach the running sequence
      tbl_addr_i = {7'h7F, 7'h7F};
      tbl_mask_i = '0;
      tbl_data_i = '1;
      wait_done(500, seen, dc);
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL rmw_done: done_o not seen within 500 cycles"); end
      n_checks++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL rmw_err: got %b want 0", err_o); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rmw_busy_at_done: got %b want 0", busy_o); end
      n_checks++;
      if (acc_addr.size() - b != 4) begin
         n_fail++; $display("FAIL rmw_access_count: got %0d want 4", acc_addr.size() - b);
      end
      if (acc_addr.size() >= b + 4) begin
         n_checks++;
         if ({acc_addr[b], acc_we[b], acc_addr[b+1], acc_we[b+1],
              acc_addr[b+2], acc_we[b+2], acc_addr[b+3], acc_we[b+3]} !==
             {7'h08, 1'b0, 7'h08, 1'b1, 7'h14, 1'b0, 7'h14, 1'b1}) begin
            n_fail++;
            $display("FAIL rmw_order: got %h/%b %h/%b %h/%b %h/%b want 08/0 08/1 14/0 14/1",
                     acc_addr[b], acc_we[b], acc_addr[b+1], acc_we[b+1],
                     acc_addr[b+2], acc_we[b+2], acc_addr[b+3], acc_we[b+3]);
         end
         n_checks++;
         if ({acc_data[b+1], acc_data[b+3]} !== {16'hA534, 16'hA534}) begin
            n_fail++;
            $display("FAIL rmw_wdata: got %h %h want a534 a534", acc_data[b+1], acc_data[b+3]);
         end
      end
      n_checks++;
      if (viol_rst != vr) begin n_fail++; $display("FAIL rmw_pll_rst: %0d accesses with pll_rst_o low, want 0", viol_rst - vr); end
      @(negedge clk_i); #1;
      n_checks++;
      if ({done_o, pll_rst_o} !== 2'b00) begin
         n_fail++; $display("FAIL rmw_after_done: done=%b pll_rst=%b want 0 0", done_o, pll_rst_o);
      end
      set_default_table();
   endtask

   task automatic test_drdy_timeout();
      bit seen; int dc; int b;
      set_default_table();
      drp_never = 1'b1;
      b = acc_addr.size();
      pulse_start();
      wait_done(300, seen, dc);
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL drdy_to_done: done_o not seen within 300 cycles"); end
      n_checks++;
      if ({err_o, err_lock_o, pll_rst_o} !== 3'b100) begin
         n_fail++; $display("FAIL drdy_to_flags: err=%b err_lock=%b pll_rst=%b want 1 0 0", err_o, err_lock_o, pll_rst_o);
      end
      n_checks++;
      if (acc_addr.size() - b != 1) begin
         n_fail++; $display("FAIL drdy_to_accesses: got %0d want 1", acc_addr.size() - b);
      end
      if (acc_addr.size() >= b + 1) begin
         n_checks++;
         if (acc_we[b] !== 1'b0) begin n_fail++; $display("FAIL drdy_to_no_write: first access dwe=%b want 0", acc_we[b]); end
         n_checks++;
         if (dc - acc_cyc[b] < 65 || dc - acc_cyc[b] > 70) begin
            n_fail++; $display("FAIL drdy_to_latency: den->done %0d cycles want 65..70", dc - acc_cyc[b]);
         end
      end
      drp_never = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit seen; int dc; int b; int d0;
      set_default_table();
      drp_delay = 1; lock_delay = 10;
      b  = acc_addr.size();
      d0 = done_cnt;
      pulse_start();
      #1;
      n_checks++;
      if ({busy_o, err_o} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_accept: busy=%b err=%b want 1 0", busy_o, err_o);
      end
      for (int i = 0; i < 3; i++) begin
         repeat (6) @(negedge clk_i);
         pulse_start();
      end
      wait_done(500, seen, dc);
      repeat (40) @(negedge clk_i);
      #1;
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done: done_o not seen within 500 cycles"); end
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); end
      n_checks++;
      if (acc_addr.size() - b != 4) begin n_fail++; $display("FAIL b2b_accesses: got %0d want 4", acc_addr.size() - b); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", busy_o); end
   endtask

   task automatic test_lock_timeout();
      bit seen; int dc; int b;
      set_default_table();
      drp_delay = 1; lock_delay = -1;
      b = acc_addr.size();
      pulse_start();
      wait_done(70000, seen, dc);
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL lock_to_done: done_o not seen within 70000 cycles"); end
      n_checks++;
      if ({err_o, err_lock_o, pll_rst_o} !== 3'b110) begin
         n_fail++; $display("FAIL lock_to_flags: err=%b err_lock=%b pll_rst=%b want 1 1 0", err_o, err_lock_o, pll_rst_o);
      end
      n_checks++;
      if (acc_addr.size() - b != 4) begin n_fail++; $display("FAIL lock_to_accesses: got %0d want 4", acc_addr.size() - b); end
      n_checks++;
      if (dc - rst_fall_cyc < 65535 || dc - rst_fall_cyc > 65540) begin
         n_fail++; $display("FAIL lock_to_latency: release->done %0d cycles want 65535..65540", dc - rst_fall_cyc);
      end
   endtask

   task automatic test_lock_rise();
      bit seen; int dc;
      set_default_table();
      drp_delay = 1; lock_delay = 100;
      pulse_start();
      wait_done(500, seen, dc);
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL lock_rise_done: done_o not seen within 500 cycles"); end
      n_checks++;
      if ({err_o, err_lock_o} !== 2'b00) begin
         n_fail++; $display("FAIL lock_rise_flags: err=%b err_lock=%b want 0 0", err_o, err_lock_o);
      end
      n_checks++;
      if (dc - lock_rise_cyc < 1 || dc - lock_rise_cyc > 3) begin
         n_fail++; $display("FAIL lock_rise_latency: rise->done %0d cycles want 1..3", dc - lock_rise_cyc);
      end
      n_checks++;
      if (dc - rst_fall_cyc < 100) begin
         n_fail++; $display("FAIL lock_rise_early: release->done %0d cycles want >= 100", dc - rst_fall_cyc);
      end
      lock_delay = 10;
   endtask

   task automatic test_mid_reset();
      bit seen; bit found; int dc; int b;
      set_default_table();
      drp_delay = 20;
      found = 1'b0;
      pulse_start();
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk_i); #1;
         if (den_o && dwe_o) found = 1'b1;
      end
      n_checks++;
      if (found !== 1'b1) begin n_fail++; $display("FAIL mid_rst_write: no write seen within 200 cycles"); end
      @(negedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i); #1;
      n_checks++;
      if ({busy_o, done_o, err_o, err_lock_o, pll_rst_o, den_o, dwe_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL mid_rst_flags: got %b want 0000000",
                  {busy_o, done_o, err_o, err_lock_o, pll_rst_o, den_o, dwe_o});
      end
      n_checks++;
      if ({daddr_o, di_o} !== 23'h0) begin
         n_fail++; $display("FAIL mid_rst_bus: daddr=%h di=%h want 0", daddr_o, di_o);
      end
      rst_i = 1'b0;
      drp_delay = 1;
      b = acc_addr.size();
      pulse_start();
      wait_done(500, seen, dc);
      n_checks++;
      if (seen !== 1'b1 || err_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_rerun: done_seen=%b err=%b want 1 0", seen, err_o);
      end
      n_checks++;
      if (acc_addr.size() - b != 4) begin n_fail++; $display("FAIL mid_rst_accesses: got %0d want 4", acc_addr.size() - b); end
      else begin
         n_checks++;
         if ({acc_addr[b+1], acc_data[b+1], acc_addr[b+3], acc_data[b+3]} !== {7'h08, 16'hA534, 7'h14, 16'hA534}) begin
            n_fail++;
            $display("FAIL mid_rst_writes: got %h:%h %h:%h want 08:a534 14:a534",
                     acc_addr[b+1], acc_data[b+1], acc_addr[b+3], acc_data[b+3]);
         end
      end
   endtask

   task automatic test_random_delay();
      bit seen; int dc; int b; int d0; int v0;
      tbl_addr_i = {7'h4F, 7'h4E};
      tbl_mask_i = {16'hFFF0, 16'h0F0F};
      tbl_data_i = {16'h0005, 16'hBEEF};
      rd_val[7'h4E] = 16'h3C3C;
      rd_val[7'h4F] = 16'hF00F;
      lock_delay = 10;
      spur_en = 1'b1;
      d0 = done_cnt;
      repeat (30) @(negedge clk_i);
      #1;
      n_checks++;
      if (done_cnt != d0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL rand_spurious_idle: done pulses=%0d busy=%b want 0 0", done_cnt - d0, busy_o);
      end
      drp_rand = 1'b1;
      v0 = viol_b2b + viol_out + viol_we + viol_rst;
      for (int r = 0; r < 3; r++) begin
         b = acc_addr.size();
         pulse_start();
         wait_done(3000, seen, dc);
         n_checks++;
         if (seen !== 1'b1 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL rand_run%0d: done_seen=%b err=%b want 1 0", r, seen, err_o);
         end
         n_checks++;
         if (acc_addr.size() - b != 4) begin
            n_fail++; $display("FAIL rand_accesses%0d: got %0d want 4", r, acc_addr.size() - b);
         end else begin
            n_checks++;
            if ({acc_addr[b+1], acc_data[b+1], acc_addr[b+3], acc_data[b+3]} !== {7'h4E, 16'hBCEC, 7'h4F, 16'hF005}) begin
               n_fail++;
               $display("FAIL rand_writes%0d: got %h:%h %h:%h want 4e:bcec 4f:f005",
                        r, acc_addr[b+1], acc_data[b+1], acc_addr[b+3], acc_data[b+3]);
            end
         end
      end
      n_checks++;
      if (viol_b2b + viol_out + viol_we + viol_rst != v0) begin
         n_fail++;
         $display("FAIL rand_protocol: b2b=%0d outstanding=%0d dwe_alone=%0d rst_low=%0d want no new events",
                  viol_b2b, viol_out, viol_we, viol_rst);
      end
      spur_en  = 1'b0;
      drp_rand = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rd_val[i] = 16'h0000;
      rst_i = 1'b1;
      start_i = 1'b0;
      set_default_table();
      test_reset();
      test_rmw();
      test_drdy_timeout();
      test_back_to_back();
      test_lock_timeout();
      test_lock_rise();
      test_mid_reset();
      test_random_delay();
      n_checks++;
      if (viol_b2b != 0 || viol_we != 0) begin
         n_fail++; $display("FAIL den_protocol: back-to-back=%0d dwe_without_den=%0d want 0 0", viol_b2b, viol_we);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
